// File: rtl/shifter_defs.sv
// Shared definitions for the iterative shifter: operation encodings,
// FSM state encodings and a sizing helper for the per-cycle amount.
package shifter_defs;

    // Operation select values on the mode port.
    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    // Controller states; kept as plain constants so older tools accept them.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Bits needed to encode a per-cycle shift amount in 0..step.
    function automatic int amt_width(input int step);
        return (step < 1) ? 1 : $clog2(step + 1);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Single combinational shift step of 0..STEP bits. Only STEP+1 fixed
// shift patterns are muxed here, so the cost tracks STEP, not WIDTH.
module shift_step
    import shifter_defs::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    parameter int AMT_W = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [1:0]       mode_i,
    input  logic [AMT_W-1:0] amt_i,
    output logic [WIDTH-1:0] data_o
);

    // Select the constant-distance shift matching amt_i; 0 passes through.
    always_comb begin
        data_o = data_i;
        for (int k = 1; k <= STEP; k++) begin
            if (amt_i == AMT_W'(k)) begin
                case (mode_i)
                    MODE_SLL: data_o = data_i << k;
                    MODE_SRL: data_o = data_i >> k;
                    MODE_SRA: data_o = $signed(data_i) >>> k;
                    default:  data_o = (data_i >> k) | (data_i << (WIDTH - k));
                endcase
            end
        end
    end

endmodule

// File: rtl/iter_shifter.sv
// Iterative shifter: captures an operand on start, shifts it by up to
// STEP bits per clock, then presents the result with a one-cycle done.
//
// Handshake: start is looked at only while busy is low (IDLE); a start seen
// there is accepted at that clock edge and busy rises on the next cycle.
// Any start while busy is high is dropped, never queued. done is high for
// exactly one cycle, and out is valid from that cycle until the next done.
module iter_shifter
    import shifter_defs::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   in,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   out,
    output logic [1:0]         dbg_state
);

    localparam int AMT_W = amt_width(STEP);

    logic [1:0]         state_q,  state_d;
    logic [WIDTH-1:0]   work_q,   work_d;
    logic [1:0]         mode_q,   mode_d;
    logic [SHAMT_W-1:0] remain_q, remain_d;
    logic [WIDTH-1:0]   out_q,    out_d;

    logic [AMT_W-1:0]   step_amt;
    logic [SHAMT_W-1:0] remain_next;
    logic [WIDTH-1:0]   step_res;

    // Bits to move this cycle: a full STEP, or whatever is left if less.
    always_comb begin
        if (int'(remain_q) >= STEP) begin
            step_amt = AMT_W'(STEP);
        end else begin
            step_amt = AMT_W'(remain_q);
        end
        remain_next = remain_q - SHAMT_W'(step_amt);
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .AMT_W (AMT_W)
    ) u_step (
        .data_i (work_q),
        .mode_i (mode_q),
        .amt_i  (step_amt),
        .data_o (step_res)
    );

    // Controller next-state: capture in IDLE, iterate in SHIFT, pulse in DONE.
    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        mode_d   = mode_q;
        remain_d = remain_q;
        out_d    = out_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    work_d   = in;
                    mode_d   = mode;
                    remain_d = shamt;
                    if (shamt == '0) begin
                        // Nothing to shift: result is the operand itself.
                        state_d = ST_DONE;
                        out_d   = in;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                work_d   = step_res;
                remain_d = remain_next;
                if (remain_next == '0) begin
                    state_d = ST_DONE;
                    out_d   = step_res;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset clearing everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            work_q   <= '0;
            mode_q   <= '0;
            remain_q <= '0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            mode_q   <= mode_d;
            remain_q <= remain_d;
            out_q    <= out_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign out       = out_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Bench for iter_shifter: three instances (32-bit step 1, 32-bit step 4,
// 28-bit step 1) driven by directed and random operations, checked against
// an arithmetic reference of each shift and its expected latency.
module tb_iter_shifter;

    logic clk;
    logic rst_n;

    logic        start_s [3];
    logic [1:0]  mode_s  [3];
    logic [4:0]  shamt_s [3];
    logic [31:0] in_s    [3];

    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic [31:0] out0, out1;
    logic [27:0] out2;
    logic [1:0]  st0, st1, st2;

    int checks = 0;
    int errors = 0;

    localparam int W_OF [3] = '{32, 32, 28};
    localparam int S_OF [3] = '{1, 4, 1};

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1, "watchdog");
    end

    iter_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .mode(mode_s[0]),
        .shamt(shamt_s[0]), .in(in_s[0]), .busy(busy0), .done(done0),
        .out(out0), .dbg_state(st0)
    );

    iter_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .mode(mode_s[1]),
        .shamt(shamt_s[1]), .in(in_s[1]), .busy(busy1), .done(done1),
        .out(out1), .dbg_state(st1)
    );

    iter_shifter #(.WIDTH(28), .SHAMT_W(5), .STEP(1)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start_s[2]), .mode(mode_s[2]),
        .shamt(shamt_s[2]), .in(in_s[2][27:0]), .busy(busy2), .done(done2),
        .out(out2), .dbg_state(st2)
    );

    function automatic logic get_busy(input int d);
        case (d)
            0:       return busy0;
            1:       return busy1;
            default: return busy2;
        endcase
    endfunction

    function automatic logic get_done(input int d);
        case (d)
            0:       return done0;
            1:       return done1;
            default: return done2;
        endcase
    endfunction

    function automatic logic [31:0] get_out(input int d);
        case (d)
            0:       return out0;
            1:       return out1;
            default: return {4'b0, out2};
        endcase
    endfunction

    // Reference result: direct arithmetic on the total shift distance.
    function automatic logic [31:0] model(input int w, input logic [1:0] m,
                                          input int sh, input logic [63:0] v_in);
        logic [63:0] mask;
        logic [63:0] v;
        logic [63:0] r;
        logic        sign;
        int          k;
        mask = (64'd1 << w) - 64'd1;
        v    = v_in & mask;
        sign = v[w-1];
        r    = '0;
        case (m)
            2'b00: r = (sh >= w) ? 64'd0 : ((v << sh) & mask);
            2'b01: r = (sh >= w) ? 64'd0 : (v >> sh);
            2'b10: begin
                if (sh >= w) begin
                    r = sign ? mask : 64'd0;
                end else begin
                    r = v >> sh;
                    if (sign) r = r | (mask & ~(mask >> sh));
                end
            end
            default: begin
                k = sh % w;
                r = ((v >> k) | (v << (w - k))) & mask;
            end
        endcase
        return r[31:0];
    endfunction

    function automatic int model_lat(input int d, input int sh);
        return (sh + S_OF[d] - 1) / S_OF[d] + 1;
    endfunction

    // Single comparison point.
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge just after start was driven. Follows the op
    // until done, checking busy each cycle. pulse_at: 0 quiet, -1 random
    // input noise each cycle, >0 a single stray start on that cycle.
    task automatic wait_done(input int d, input int exp_lat, input logic [31:0] exp_out,
                             input string tag, input int pulse_at);
        int lat;
        bit seen;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 100) begin
            @(negedge clk);
            lat++;
            if (pulse_at < 0) begin
                start_s[d] = 1'($urandom_range(0, 1));
                mode_s[d]  = 2'($urandom);
                shamt_s[d] = 5'($urandom);
                in_s[d]    = $urandom;
            end else if (pulse_at == lat) begin
                start_s[d] = 1'b1;
                mode_s[d]  = ~mode_s[d];
                shamt_s[d] = 5'd1;
                in_s[d]    = ~in_s[d];
            end else begin
                start_s[d] = 1'b0;
            end
            if (get_done(d)) seen = 1'b1;
            else check({tag, " busy"}, 64'(get_busy(d)), 64'd1);
        end
        check({tag, " done_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            check({tag, " latency"}, 64'(lat), 64'(exp_lat));
            check({tag, " out"}, 64'(get_out(d)), 64'(exp_out));
        end
    endtask

    // Full operation, then confirm the done pulse ended and out holds.
    task automatic run_op(input int d, input logic [1:0] m, input int sh,
                          input logic [31:0] val, input string tag, input int pulse_at);
        logic [31:0] e;
        e = model(W_OF[d], m, sh, 64'(val));
        @(negedge clk);
        start_s[d] = 1'b1;
        mode_s[d]  = m;
        shamt_s[d] = 5'(sh);
        in_s[d]    = val;
        wait_done(d, model_lat(d, sh), e, tag, pulse_at);
        start_s[d] = 1'b0;
        @(negedge clk);
        check({tag, " done_one_cycle"}, 64'(get_done(d)), 64'd0);
        check({tag, " idle_after"}, 64'(get_busy(d)), 64'd0);
        check({tag, " out_hold"}, 64'(get_out(d)), 64'(e));
    endtask

    initial begin
        logic [31:0] ea;
        logic [31:0] eb;
        int          d;
        int          sh;
        logic [1:0]  m;
        logic [31:0] v;

        // Reset.
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_s[i] = 1'b0;
            mode_s[i]  = 2'b00;
            shamt_s[i] = 5'd0;
            in_s[i]    = 32'd0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("reset busy", 64'(get_busy(i)), 64'd0);
            check("reset done", 64'(get_done(i)), 64'd0);
            check("reset out", 64'(get_out(i)), 64'd0);
        end
        rst_n = 1'b1;

        // Directed cases.
        run_op(0, 2'b00, 2,  32'd10,        "sll_10_by_2", 0);
        run_op(0, 2'b00, 2,  32'hFFFF_FFFF, "sll_ones_by_2", 0);
        run_op(0, 2'b00, 0,  32'hFFFF_FFFF, "sll_ones_by_0", 0);
        run_op(0, 2'b10, 31, 32'h8000_0000, "sra_msb_by_31", 0);
        run_op(0, 2'b01, 31, 32'h8000_0000, "srl_msb_by_31", 0);
        run_op(1, 2'b11, 4,  32'h0000_0001, "s4_ror_1_by_4", 0);
        run_op(1, 2'b00, 5,  32'h0000_0001, "s4_sll_1_by_5", 0);
        run_op(1, 2'b11, 31, 32'h1234_5678, "s4_ror_by_31", 0);
        run_op(1, 2'b10, 0,  32'h8765_4321, "s4_sra_by_0", 0);
        run_op(2, 2'b00, 2,  32'h03FF_FFFF, "w28_sll_by_2", 0);
        run_op(2, 2'b00, 30, 32'h03FF_FFFF, "w28_sll_by_30", 0);
        run_op(2, 2'b10, 30, 32'h0800_0001, "w28_sra_by_30", 0);
        run_op(2, 2'b11, 29, 32'h0000_0003, "w28_ror_by_29", 0);

        // Stray start on cycle 3 of an SLL by 8 must be ignored.
        run_op(0, 2'b00, 8,  32'h0000_00A5, "ignore_stray_start", 3);

        // Back-to-back: start stays high through done into the next IDLE.
        ea = model(32, 2'b11, 6, 64'(32'hCAFE_0001));
        eb = model(32, 2'b10, 3, 64'(32'hF000_0000));
        @(negedge clk);
        start_s[1] = 1'b1; mode_s[1] = 2'b11; shamt_s[1] = 5'd6; in_s[1] = 32'hCAFE_0001;
        wait_done(1, model_lat(1, 6), ea, "b2b_first", 0);
        start_s[1] = 1'b1; mode_s[1] = 2'b10; shamt_s[1] = 5'd3; in_s[1] = 32'hF000_0000;
        @(negedge clk);
        check("b2b gap done", 64'(done1), 64'd0);
        check("b2b gap busy", 64'(busy1), 64'd0);
        wait_done(1, model_lat(1, 3), eb, "b2b_second", 0);
        start_s[1] = 1'b0;
        @(negedge clk);

        // Reset on cycle 4 of an operation aborts it.
        @(negedge clk);
        start_s[0] = 1'b1; mode_s[0] = 2'b00; shamt_s[0] = 5'd8; in_s[0] = 32'h0000_0001;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start_s[0] = 1'b0;
            if (c < 4) check("abort pre busy", 64'(busy0), 64'd1);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort busy", 64'(busy0), 64'd0);
        check("abort done", 64'(done0), 64'd0);
        check("abort out", 64'(out0), 64'd0);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check("abort no_done", 64'(done0), 64'd0);
            check("abort out_zero", 64'(out0), 64'd0);
        end
        run_op(0, 2'b01, 4, 32'hF0F0_F0F0, "after_abort", 0);

        // Random operations with noisy inputs while busy.
        for (int n = 0; n < 40; n++) begin
            d  = $urandom_range(0, 2);
            m  = 2'($urandom);
            sh = $urandom_range(0, 31);
            v  = $urandom;
            run_op(d, m, sh, v, $sformatf("rand%0d_d%0d_m%0d_s%0d", n, d, m, sh), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
